// File: rtl/ctrl_pipe_if.sv
// Decode-side handshake into the control-word pipeline.
// The master drives a word plus its valid flag; the pipe answers with in_ready.
interface ctrl_pipe_if #(
  parameter int unsigned W = 26
);
  logic [W-1:0] in_ctrl;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output in_ctrl,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_ctrl,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control-word pipeline from Decode through STAGES registered stages, with
// per-stage stall/flush, upstream stall propagation, bubble insertion and kill masking.
module ctrl_pipe #(
  parameter int unsigned  W          = 26,
  parameter int unsigned  STAGES     = 4,
  parameter int unsigned  KILL_STAGE = 0,
  parameter logic [W-1:0] KILL_MASK  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  ctrl_pipe_if.slave                   up,
  input  logic [STAGES-1:0]            stall,
  input  logic [STAGES-1:0]            flush,
  input  logic                         kill,
  output logic [STAGES*W-1:0]          stage_ctrl,
  output logic [STAGES-1:0]            stage_valid,
  output logic                         killed,
  output logic [$clog2(STAGES+1)-1:0]  count
);

  localparam int unsigned CW = $clog2(STAGES+1);

  logic [W-1:0]      ctrlQ   [STAGES];
  logic [STAGES-1:0] validQ;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] upHold;
  logic [W-1:0]      srcCtrl [STAGES];
  logic [STAGES-1:0] srcValid;
  logic [W-1:0]      ctrlD   [STAGES];
  logic [STAGES-1:0] validD;
  logic [CW-1:0]     countD;

  // A stage holds if it or any stage downstream of it stalls.
  always_comb begin
    hold = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      hold[i] = |(stall >> i);
    end
  end

  assign upHold      = {hold[STAGES-2:0], 1'b0};
  assign up.in_ready = ~hold[0];
  assign killed      = kill & validQ[KILL_STAGE];

  always_comb begin
    srcCtrl[0]  = up.in_valid ? up.in_ctrl : '0;
    srcValid[0] = up.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      srcCtrl[k]  = ctrlQ[k-1];
      srcValid[k] = validQ[k-1];
      if ((k - 1 == KILL_STAGE) && killed) begin
        srcCtrl[k] = ctrlQ[k-1] & ~KILL_MASK;
      end
    end
  end

  // Priority per stage: flush, hold, bubble behind a held stage, then load.
  always_comb begin
    validD = '0;
    countD = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      ctrlD[k] = '0;
      if (flush[k]) begin
        ctrlD[k]  = '0;
        validD[k] = 1'b0;
      end else if (hold[k]) begin
        ctrlD[k]  = ctrlQ[k];
        validD[k] = validQ[k];
      end else if (upHold[k]) begin
        ctrlD[k]  = '0;
        validD[k] = 1'b0;
      end else begin
        ctrlD[k]  = srcCtrl[k];
        validD[k] = srcValid[k];
      end
      countD = countD + CW'(validD[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrlQ[k] <= '0;
      end
      validQ <= '0;
      count  <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrlQ[k] <= ctrlD[k];
      end
      validQ <= validD;
      count  <= countD;
    end
  end

  always_comb begin
    stage_ctrl = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      stage_ctrl[k*W +: W] = ctrlQ[k];
    end
  end

  assign stage_valid = validQ;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed table-driven bench for ctrl_pipe (W=8, STAGES=4, KILL_STAGE=1, KILL_MASK=8'h0E).
// Stage words are compared packed as {s3,s2,s1,s0}.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  stall;
  logic [3:0]  flush;
  logic        kill;
  logic [31:0] stageCtrl;
  logic [3:0]  stageValid;
  logic        killed;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.W(8)) bus ();

  ctrl_pipe #(
    .W(8),
    .STAGES(4),
    .KILL_STAGE(1),
    .KILL_MASK(8'h0E)
  ) dut (
    .clk(clk),
    .reset(reset),
    .up(bus.slave),
    .stall(stall),
    .flush(flush),
    .kill(kill),
    .stage_ctrl(stageCtrl),
    .stage_valid(stageValid),
    .killed(killed),
    .count(count)
  );

  typedef struct {
    logic [7:0]  inCtrl;
    logic        inValid;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        kill;
    logic        expReady;
    logic        expKilled;
    logic [31:0] expCtrl;
    logic [3:0]  expValid;
    logic [2:0]  expCount;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] c, logic v, logic [3:0] st, logic [3:0] fl,
                              logic kl, logic rdy, logic kld, logic [31:0] ec,
                              logic [3:0] ev, logic [2:0] cnt);
    vec_t r;
    r.inCtrl = c;   r.inValid = v;    r.stall = st;    r.flush = fl;  r.kill = kl;
    r.expReady = rdy; r.expKilled = kld; r.expCtrl = ec; r.expValid = ev; r.expCount = cnt;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkState(string tag, logic [31:0] ec, logic [3:0] ev, logic [2:0] cnt);
    chk({tag, " stage_ctrl"}, stageCtrl, ec);
    chk({tag, " stage_valid"}, 32'(stageValid), 32'(ev));
    chk({tag, " count"}, 32'(count), 32'(cnt));
  endtask

  initial begin
    // fill, then stall/flush/kill corners; each row is one clock
    vecs.push_back(mk(8'h11, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h00000011, 4'b0001, 1));
    vecs.push_back(mk(8'h22, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h00001122, 4'b0011, 2));
    vecs.push_back(mk(8'h33, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h00112233, 4'b0111, 3));
    vecs.push_back(mk(8'h44, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h11223344, 4'b1111, 4));
    vecs.push_back(mk(8'hA1, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h223344A1, 4'b1111, 4));
    vecs.push_back(mk(8'hA2, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h3344A1A2, 4'b1111, 4));
    vecs.push_back(mk(8'hA3, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h44A1A2A3, 4'b1111, 4));
    vecs.push_back(mk(8'hA4, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'hA1A2A3A4, 4'b1111, 4));
    vecs.push_back(mk(8'h55, 1, 4'b0010, 4'b0000, 0, 0, 0, 32'hA200A3A4, 4'b1011, 3));
    vecs.push_back(mk(8'h55, 1, 4'b0010, 4'b0000, 0, 0, 0, 32'h0000A3A4, 4'b0011, 2));
    vecs.push_back(mk(8'h55, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h00A3A455, 4'b0111, 3));
    vecs.push_back(mk(8'h66, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'hA3A45566, 4'b1111, 4));
    vecs.push_back(mk(8'h77, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'hA4556677, 4'b1111, 4));
    vecs.push_back(mk(8'h88, 1, 4'b0100, 4'b0100, 0, 0, 0, 32'h00006677, 4'b0011, 2));
    vecs.push_back(mk(8'h88, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h00667788, 4'b0111, 3));
    vecs.push_back(mk(8'hFF, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h667788FF, 4'b1111, 4));
    vecs.push_back(mk(8'h01, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h7788FF01, 4'b1111, 4));
    vecs.push_back(mk(8'h02, 1, 4'b0000, 4'b0000, 1, 1, 1, 32'h88F10102, 4'b1111, 4));
    vecs.push_back(mk(8'hFF, 0, 4'b0000, 4'b0000, 0, 1, 0, 32'hF1010200, 4'b1110, 3));
    vecs.push_back(mk(8'h03, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h01020003, 4'b1101, 3));
    vecs.push_back(mk(8'h04, 1, 4'b0000, 4'b0000, 1, 1, 0, 32'h02000304, 4'b1011, 3));
    vecs.push_back(mk(8'h05, 1, 4'b0010, 4'b0000, 1, 0, 1, 32'h00000304, 4'b0011, 2));
    vecs.push_back(mk(8'h05, 1, 4'b0000, 4'b0100, 1, 1, 1, 32'h00000405, 4'b0011, 2));
    vecs.push_back(mk(8'h06, 1, 4'b0000, 4'b0001, 0, 1, 0, 32'h00040500, 4'b0110, 2));
    vecs.push_back(mk(8'h07, 1, 4'b1000, 4'b0000, 0, 0, 0, 32'h00040500, 4'b0110, 2));
    vecs.push_back(mk(8'h07, 1, 4'b0000, 4'b0000, 0, 1, 0, 32'h04050007, 4'b1101, 3));

    reset        = 1'b0;
    stall        = '0;
    flush        = '0;
    kill         = 1'b0;
    bus.in_ctrl  = 8'hFF;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkState("reset", 32'h0, 4'b0000, 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.in_ctrl  = vecs[i].inCtrl;
      bus.in_valid = vecs[i].inValid;
      stall        = vecs[i].stall;
      flush        = vecs[i].flush;
      kill         = vecs[i].kill;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].expReady));
      chk($sformatf("vec%0d killed", i), 32'(killed), 32'(vecs[i].expKilled));
      @(posedge clk);
      #1;
      checkState($sformatf("vec%0d", i), vecs[i].expCtrl, vecs[i].expValid, vecs[i].expCount);
    end

    // full hold with three valid stages, then asynchronous reset mid-cycle
    bus.in_ctrl  = 8'h08;
    bus.in_valid = 1'b1;
    stall        = 4'b1000;
    flush        = '0;
    kill         = 1'b0;
    #1;
    chk("midstall in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkState("midstall", 32'h04050007, 4'b1101, 3);
    #2;
    reset = 1'b0;
    #1;
    checkState("async reset", 32'h0, 4'b0000, 0);
    chk("async reset in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkState("post reset", 32'h0, 4'b0000, 0);

    stall        = '0;
    bus.in_ctrl  = 8'h11;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    checkState("first load", 32'h00000011, 4'b0001, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
